// File: rtl/rom_signals_pkg.sv
// Shared definitions for the control-signal ROM sequencer.
// Contents: default width localparams and the sequencer FSM state encoding.
// Optional feature macro used by the sequencer: ROM_SIGNALS_LOOP_EN.
package rom_signals_pkg;

    localparam int ROM_SIG_WIDTH_DEF   = 10;
    localparam int SIG_ADDRS_WIDTH_DEF = 10;
    localparam int HOLD_WIDTH_DEF      = 8;
    localparam int LOOP_WIDTH_DEF      = 8;

    // Plain vector encoding keeps the state register compatible with older tools.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/rom_signals_hold_counter.sv
// Loadable down-counter that times how long each control word stays valid.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   load         : load load_value (has priority over en)
//   load_value   : value loaded on load
//   en           : decrement enable (low while the sequence is stalled)
//   zero         : count is zero
// The counter saturates at zero rather than wrapping.
module rom_signals_hold_counter
    import rom_signals_pkg::*;
#(
    parameter int WIDTH = HOLD_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load, decrement when enabled, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/rom_signals_sequencer.sv
// Sequencer for the control-signal ROM. A start pulse latches an inclusive
// address window and a hold count; the block then fetches each word, holds
// it valid for hold+1 unstalled cycles and prefetches the next word in the
// last hold cycle so consecutive words are issued without a bubble.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : start request (ignored while busy)
//   first_addrs_i         : first ROM address of the window
//   last_addrs_i          : last ROM address of the window (inclusive)
//   hold_cycles_i         : each word is valid for hold+1 cycles
//   stall_i               : freezes the hold counter and prefetch
//   abort_i               : ends the sequence without done_o
//   loop_count_i          : extra passes (only with ROM_SIGNALS_LOOP_EN)
//   addrs_rom_signal_o    : ROM address
//   rd_rom_signals_ld_o   : ROM read strobe
//   rom_signals_data_i    : ROM data, combinational from the address
//   ctrl_word_o           : registered control word, 0 when not valid
//   ctrl_valid_o          : control word valid
//   busy_o                : sequence in progress
//   done_o                : one-cycle pulse on normal completion
// Optional feature: define ROM_SIGNALS_LOOP_EN to add multi-pass looping.
//
// The ROM address and strobe are combinational: the prefetch must present
// the next address in the same cycle the hold counter expires, and whether
// that happens depends on stall_i/abort_i in that cycle.
module rom_signals_sequencer
    import rom_signals_pkg::*;
#(
    parameter int ROM_SIG_WIDTH   = ROM_SIG_WIDTH_DEF,
    parameter int SIG_ADDRS_WIDTH = SIG_ADDRS_WIDTH_DEF,
    parameter int HOLD_WIDTH      = HOLD_WIDTH_DEF,
    parameter int LOOP_WIDTH      = LOOP_WIDTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [SIG_ADDRS_WIDTH-1:0] first_addrs_i,
    input  logic [SIG_ADDRS_WIDTH-1:0] last_addrs_i,
    input  logic [HOLD_WIDTH-1:0]      hold_cycles_i,
    input  logic                       stall_i,
    input  logic                       abort_i,
`ifdef ROM_SIGNALS_LOOP_EN
    input  logic [LOOP_WIDTH-1:0]      loop_count_i,
`endif
    output logic [SIG_ADDRS_WIDTH-1:0] addrs_rom_signal_o,
    output logic                       rd_rom_signals_ld_o,
    input  logic [ROM_SIG_WIDTH-1:0]   rom_signals_data_i,
    output logic [ROM_SIG_WIDTH-1:0]   ctrl_word_o,
    output logic                       ctrl_valid_o,
    output logic                       busy_o,
    output logic                       done_o
);

    state_t                     state_r;
    state_t                     next_state_s;
    logic [SIG_ADDRS_WIDTH-1:0] addr_r;
    logic [SIG_ADDRS_WIDTH-1:0] first_r;
    logic [SIG_ADDRS_WIDTH-1:0] last_r;
    logic [HOLD_WIDTH-1:0]      hold_r;
    logic [ROM_SIG_WIDTH-1:0]   ctrl_word_r;
    logic                       ctrl_valid_r;
    logic                       busy_r;
    logic                       done_r;

    logic                       accept_start_s;
    logic                       advance_s;
    logic                       capture_s;
    logic                       load_cnt_s;
    logic                       dec_cnt_s;
    logic                       cnt_zero_s;
    logic                       is_last_s;
    logic [SIG_ADDRS_WIDTH-1:0] next_addr_s;

`ifdef ROM_SIGNALS_LOOP_EN
    logic [LOOP_WIDTH-1:0]      passes_r;
    logic                       pass_dec_s;
`endif

    assign is_last_s      = (addr_r == last_r);
    assign accept_start_s = (state_r == ST_IDLE) && start_i && !abort_i;

    // Next-state, prefetch and counter control.
    always_comb begin
        next_state_s = state_r;
        advance_s    = 1'b0;
        capture_s    = 1'b0;
        load_cnt_s   = 1'b0;
        dec_cnt_s    = 1'b0;
        next_addr_s  = addr_r;
`ifdef ROM_SIGNALS_LOOP_EN
        pass_dec_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_start_s) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                    capture_s    = 1'b1;
                    load_cnt_s   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (abort_i) begin
                    next_state_s = ST_IDLE;
                end else if (stall_i) begin
                    next_state_s = ST_HOLD;
                end else if (!cnt_zero_s) begin
                    dec_cnt_s    = 1'b1;
                end else if (!is_last_s) begin
                    // Prefetch: fetch the next word in the final hold cycle.
                    advance_s    = 1'b1;
                    capture_s    = 1'b1;
                    load_cnt_s   = 1'b1;
                    next_addr_s  = addr_r + {{(SIG_ADDRS_WIDTH-1){1'b0}}, 1'b1};
`ifdef ROM_SIGNALS_LOOP_EN
                end else if (passes_r != {LOOP_WIDTH{1'b0}}) begin
                    // Another pass: restart at the first address, still gapless.
                    advance_s    = 1'b1;
                    capture_s    = 1'b1;
                    load_cnt_s   = 1'b1;
                    pass_dec_s   = 1'b1;
                    next_addr_s  = first_r;
`endif
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // ROM address and strobe: the register value except during a prefetch.
    always_comb begin
        if (advance_s) begin
            addrs_rom_signal_o = next_addr_s;
        end else begin
            addrs_rom_signal_o = addr_r;
        end
        rd_rom_signals_ld_o = (state_r == ST_FETCH) || advance_s;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Window/hold latches and the current address register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r  <= {SIG_ADDRS_WIDTH{1'b0}};
            first_r <= {SIG_ADDRS_WIDTH{1'b0}};
            last_r  <= {SIG_ADDRS_WIDTH{1'b0}};
            hold_r  <= {HOLD_WIDTH{1'b0}};
        end else if (accept_start_s) begin
            addr_r  <= first_addrs_i;
            first_r <= first_addrs_i;
            last_r  <= last_addrs_i;
            hold_r  <= hold_cycles_i;
        end else if (advance_s) begin
            addr_r  <= next_addr_s;
        end else begin
            addr_r  <= addr_r;
        end
    end

`ifdef ROM_SIGNALS_LOOP_EN
    // Remaining extra passes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            passes_r <= {LOOP_WIDTH{1'b0}};
        end else if (accept_start_s) begin
            passes_r <= loop_count_i;
        end else if (pass_dec_s) begin
            passes_r <= passes_r - {{(LOOP_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            passes_r <= passes_r;
        end
    end
`endif

    // Registered datapath outputs; the word is forced to 0 outside HOLD.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_word_r  <= {ROM_SIG_WIDTH{1'b0}};
            ctrl_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (capture_s) begin
                ctrl_word_r <= rom_signals_data_i;
            end else if (next_state_s != ST_HOLD) begin
                ctrl_word_r <= {ROM_SIG_WIDTH{1'b0}};
            end else begin
                ctrl_word_r <= ctrl_word_r;
            end
            ctrl_valid_r <= (next_state_s == ST_HOLD);
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (next_state_s == ST_DONE);
        end
    end

    rom_signals_hold_counter #(
        .WIDTH (HOLD_WIDTH)
    ) u_hold_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (load_cnt_s),
        .load_value (hold_r),
        .en         (dec_cnt_s),
        .zero       (cnt_zero_s)
    );

    assign ctrl_word_o  = ctrl_word_r;
    assign ctrl_valid_o = ctrl_valid_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_rom_signals_sequencer.sv
// Directed bench for rom_signals_sequencer. A behavioural ROM returns a
// scrambled function of the address; each cycle the bench packs
// {strobe, address, valid, word, done, busy} and compares it with a
// hand-derived expectation. Define ROM_SIGNALS_LOOP_EN to add the loop test.
module tb_rom_signals_sequencer;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [9:0] first_i = 10'd0;
    logic [9:0] last_i = 10'd0;
    logic [7:0] hold_i = 8'd0;
    logic       stall_i = 1'b0;
    logic       abort_i = 1'b0;
`ifdef ROM_SIGNALS_LOOP_EN
    logic [7:0] loop_i = 8'd0;
`endif
    logic [9:0] addr_o;
    logic       rd_o;
    logic [9:0] rom_data;
    logic [9:0] word_o;
    logic       valid_o;
    logic       busy_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [9:0] rom_f(input logic [9:0] a);
        logic [9:0] t;
        t = (a * 10'd37) + 10'd5;
        return t ^ 10'h155;
    endfunction

    assign rom_data = rom_f(addr_o);

    logic [23:0] obs;
    assign obs = {rd_o, addr_o, valid_o, word_o, done_o, busy_o};

    rom_signals_sequencer dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .start_i             (start_i),
        .first_addrs_i       (first_i),
        .last_addrs_i        (last_i),
        .hold_cycles_i       (hold_i),
        .stall_i             (stall_i),
        .abort_i             (abort_i),
`ifdef ROM_SIGNALS_LOOP_EN
        .loop_count_i        (loop_i),
`endif
        .addrs_rom_signal_o  (addr_o),
        .rd_rom_signals_ld_o (rd_o),
        .rom_signals_data_i  (rom_data),
        .ctrl_word_o         (word_o),
        .ctrl_valid_o        (valid_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== 24'd0) begin
                errors++;
                $display("FAIL reset c=%0d got %h expected %h", c, obs, 24'd0);
            end
        end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // k words, hold=0, window f..l; strobe/address/valid/done each cycle.
    task automatic test_window(input logic [9:0] f, input logic [9:0] l, input int k);
        logic [9:0]  ea;
        logic [9:0]  ew;
        logic        ev;
        logic [23:0] ex;
        @(negedge clk);
        first_i = f; last_i = l; hold_i = 8'd0; start_i = 1'b1;
        for (int c = 0; c < k + 3; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            ea = (c < k) ? (f + 10'(c)) : l;
            ev = (c >= 1) && (c <= k);
            ew = ev ? rom_f(f + 10'(c - 1)) : 10'd0;
            ex = {(c < k), ea, ev, ew, (c == k + 1), (c <= k + 1)};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL window f=%0d c=%0d got %h expected %h", f, c, obs, ex);
            end
        end
    endtask

    // first=7,last=8,hold=2, stall in cycles 2,3: word 7 valid for 5 cycles.
    task automatic test_stall();
        logic [9:0]  ea;
        logic [9:0]  ew;
        logic        ev;
        logic        er;
        logic [23:0] ex;
        @(negedge clk);
        first_i = 10'd7; last_i = 10'd8; hold_i = 8'd2; start_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            stall_i = (c == 2) || (c == 3);
            #1;
            er = (c == 0) || (c == 5);
            ea = (c < 5) ? 10'd7 : 10'd8;
            ev = (c >= 1) && (c <= 8);
            ew = (c >= 1 && c <= 5) ? rom_f(10'd7) : ((c >= 6 && c <= 8) ? rom_f(10'd8) : 10'd0);
            ex = {er, ea, ev, ew, (c == 9), (c <= 9)};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL stall c=%0d got %h expected %h", c, obs, ex);
            end
        end
        stall_i = 1'b0;
    endtask

    // Abort while the second word is showing.
    task automatic test_abort();
        logic [23:0] ex;
        @(negedge clk);
        first_i = 10'd10; last_i = 10'd20; hold_i = 8'd1; start_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            abort_i = (c == 3);
            #1;
            case (c)
                0:       ex = {1'b1, 10'd10, 1'b0, 10'd0, 1'b0, 1'b1};
                1:       ex = {1'b0, 10'd10, 1'b1, rom_f(10'd10), 1'b0, 1'b1};
                2:       ex = {1'b1, 10'd11, 1'b1, rom_f(10'd10), 1'b0, 1'b1};
                3:       ex = {1'b0, 10'd11, 1'b1, rom_f(10'd11), 1'b0, 1'b1};
                default: ex = {1'b0, 10'd11, 1'b0, 10'd0, 1'b0, 1'b0};
            endcase
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL abort c=%0d got %h expected %h", c, obs, ex);
            end
        end
        abort_i = 1'b0;
    endtask

    // Start while busy is dropped; reset mid-sequence clears everything.
    task automatic test_start_busy_reset();
        logic [23:0] ex;
        @(negedge clk);
        first_i = 10'd0; last_i = 10'd3; hold_i = 8'd3; start_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start_i = (c == 1);
            if (c == 1) begin
                first_i = 10'd50; last_i = 10'd60;
            end
            rst_i = (c == 2);
            #1;
            case (c)
                0:       ex = {1'b1, 10'd0, 1'b0, 10'd0, 1'b0, 1'b1};
                1, 2:    ex = {1'b0, 10'd0, 1'b1, rom_f(10'd0), 1'b0, 1'b1};
                default: ex = 24'd0;
            endcase
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL busy_reset c=%0d got %h expected %h", c, obs, ex);
            end
        end
        rst_i = 1'b0;
        start_i = 1'b0;
    endtask

`ifdef ROM_SIGNALS_LOOP_EN
    // first=2,last=3,loop=2: addresses 2,3,2,3,2,3 then one done pulse.
    task automatic test_loop();
        logic [9:0]  ea;
        logic [9:0]  ew;
        logic        ev;
        logic [23:0] ex;
        @(negedge clk);
        first_i = 10'd2; last_i = 10'd3; hold_i = 8'd0; loop_i = 8'd2; start_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            ea = (c < 6) ? (10'd2 + 10'(c % 2)) : 10'd3;
            ev = (c >= 1) && (c <= 6);
            ew = ev ? rom_f(10'd2 + 10'((c - 1) % 2)) : 10'd0;
            ex = {(c < 6), ea, ev, ew, (c == 7), (c <= 7)};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL loop c=%0d got %h expected %h", c, obs, ex);
            end
        end
        loop_i = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_window(10'd3, 10'd5, 3);
        test_stall();
        test_window(10'd1022, 10'd1, 4);
        test_window(10'd9, 10'd9, 1);
        test_abort();
        test_window(10'd4, 10'd5, 2);
        test_start_busy_reset();
        test_window(10'd100, 10'd101, 2);
`ifdef ROM_SIGNALS_LOOP_EN
        test_loop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
